// File: rtl/rf_window_ctrl_if.sv
// Control-unit / RF / data-memory side of the window-pointer controller.
interface rf_window_ctrl_if #(
    parameter int unsigned DW     = 16,
    parameter int unsigned MEM_AW = 8,
    parameter int unsigned CW     = 3,
    parameter int unsigned DEPW   = 7,
    parameter int unsigned RAW    = 2
);
    logic              call;
    logic              ret;
    logic              busy;
    logic              err;
    logic [CW-1:0]     cwp;
    logic [DEPW-1:0]   depth;
    logic [CW-1:0]     rf_wnd;
    logic [RAW-1:0]    rf_addr;
    logic              rf_we;
    logic [DW-1:0]     rf_wdata;
    logic [DW-1:0]     rf_rdata;
    logic [MEM_AW-1:0] mem_addr;
    logic              mem_we;
    logic              mem_re;
    logic [DW-1:0]     mem_wdata;
    logic [DW-1:0]     mem_rdata;

    // Core / RF / memory side
    modport master (
        output call, ret, rf_rdata, mem_rdata,
        input  busy, err, cwp, depth, rf_wnd, rf_addr, rf_we, rf_wdata,
               mem_addr, mem_we, mem_re, mem_wdata
    );

    // Controller side
    modport slave (
        input  call, ret, rf_rdata, mem_rdata,
        output busy, err, cwp, depth, rf_wnd, rf_addr, rf_we, rf_wdata,
               mem_addr, mem_we, mem_re, mem_wdata
    );
endinterface

// File: rtl/rf_window_ctrl.sv
// Window-pointer controller: tracks CWP/depth and spills/fills RF windows to memory.
module rf_window_ctrl #(
    parameter int unsigned       DW         = 16,
    parameter int unsigned       NREG       = 8,
    parameter int unsigned       WND_STEP   = 2,
    parameter int unsigned       MEM_AW     = 8,
    parameter logic [MEM_AW-1:0] SPILL_BASE = 8'h80,
    parameter int unsigned       MAX_DEPTH  = 64
) (
    input  logic             clk,
    input  logic             rst,
    rf_window_ctrl_if.slave  bus
);
    localparam int unsigned NWIN = NREG / WND_STEP;
    localparam int unsigned CW   = $clog2(NREG);
    localparam int unsigned IW   = (WND_STEP > 1) ? $clog2(WND_STEP) : 1;
    localparam int unsigned RW   = $clog2(NWIN);
    localparam int unsigned DEPW = $clog2(MAX_DEPTH + 1);
    localparam int unsigned RAW  = 2;

    typedef enum logic [1:0] {S_IDLE, S_SPILL, S_FILL_RD, S_FILL_WR} state_t;

    state_t            r_state, w_state_n;
    logic [CW-1:0]     r_cwp,   w_cwp_n;
    logic [RW-1:0]     r_res,   w_res_n;
    logic [DEPW-1:0]   r_depth, w_depth_n;
    logic [MEM_AW-1:0] r_sp,    w_sp_n;
    logic [IW-1:0]     r_i,     w_i_n;
    logic              w_err_n;

    logic              r_busy, r_err, r_rf_we, r_mem_we, r_mem_re;
    logic [CW-1:0]     r_rf_wnd;
    logic [RAW-1:0]    r_rf_addr;
    logic [MEM_AW-1:0] r_mem_addr;
    logic              w_busy_n, w_rf_we_n, w_mem_we_n, w_mem_re_n;
    logic [CW-1:0]     w_rf_wnd_n;
    logic [RAW-1:0]    w_rf_addr_n;
    logic [MEM_AW-1:0] w_mem_addr_n;

    // State and pointer registers; reset aborts any transfer in progress
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cwp   <= '0;
            r_res   <= RW'(1);
            r_depth <= '0;
            r_sp    <= '0;
            r_i     <= '0;
        end else begin
            r_state <= w_state_n;
            r_cwp   <= w_cwp_n;
            r_res   <= w_res_n;
            r_depth <= w_depth_n;
            r_sp    <= w_sp_n;
            r_i     <= w_i_n;
        end
    end

    // Next-state and pointer update for call/return servicing and spill/fill sequencing
    always_comb begin
        w_state_n = r_state;
        w_cwp_n   = r_cwp;
        w_res_n   = r_res;
        w_depth_n = r_depth;
        w_sp_n    = r_sp;
        w_i_n     = r_i;
        w_err_n   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (bus.call && bus.ret) begin
                    w_err_n = 1'b1;
                end else if (bus.call) begin
                    if (r_depth == DEPW'(MAX_DEPTH)) begin
                        w_err_n = 1'b1;
                    end else if (r_res < RW'(NWIN - 1)) begin
                        w_cwp_n   = r_cwp + CW'(WND_STEP);
                        w_res_n   = r_res + RW'(1);
                        w_depth_n = r_depth + DEPW'(1);
                    end else begin
                        w_state_n = S_SPILL;
                        w_i_n     = '0;
                    end
                end else if (bus.ret) begin
                    if (r_depth == '0) begin
                        w_err_n = 1'b1;
                    end else if (r_res > RW'(1)) begin
                        w_cwp_n   = r_cwp - CW'(WND_STEP);
                        w_res_n   = r_res - RW'(1);
                        w_depth_n = r_depth - DEPW'(1);
                    end else begin
                        w_sp_n    = r_sp - MEM_AW'(WND_STEP);
                        w_state_n = S_FILL_RD;
                        w_i_n     = '0;
                    end
                end
            end
            S_SPILL: begin
                if (r_i == IW'(WND_STEP - 1)) begin
                    w_cwp_n   = r_cwp + CW'(WND_STEP);
                    w_depth_n = r_depth + DEPW'(1);
                    w_sp_n    = r_sp + MEM_AW'(WND_STEP);
                    w_i_n     = '0;
                    w_state_n = S_IDLE;
                end else begin
                    w_i_n = r_i + IW'(1);
                end
            end
            S_FILL_RD: begin
                w_state_n = S_FILL_WR;
            end
            S_FILL_WR: begin
                if (r_i < IW'(WND_STEP - 1)) begin
                    w_i_n     = r_i + IW'(1);
                    w_state_n = S_FILL_RD;
                end else begin
                    w_cwp_n   = r_cwp - CW'(WND_STEP);
                    w_depth_n = r_depth - DEPW'(1);
                    w_i_n     = '0;
                    w_state_n = S_IDLE;
                end
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    // Output decode from the upcoming state so every strobe/address leaves a flop
    always_comb begin
        w_busy_n     = (w_state_n != S_IDLE);
        w_rf_we_n    = (w_state_n == S_FILL_WR);
        w_mem_we_n   = (w_state_n == S_SPILL);
        w_mem_re_n   = (w_state_n == S_FILL_RD);
        w_rf_wnd_n   = w_cwp_n;
        w_rf_addr_n  = '0;
        w_mem_addr_n = SPILL_BASE + w_sp_n + MEM_AW'(w_i_n);
        unique case (w_state_n)
            S_SPILL: begin
                // oldest resident window base
                w_rf_wnd_n  = w_cwp_n - CW'((int'(w_res_n) - 1) * int'(WND_STEP));
                w_rf_addr_n = RAW'(w_i_n);
            end
            S_FILL_RD: begin
                w_rf_wnd_n = w_cwp_n - CW'(WND_STEP);
            end
            S_FILL_WR: begin
                w_rf_wnd_n  = w_cwp_n - CW'(WND_STEP);
                w_rf_addr_n = RAW'(w_i_n);
            end
            default: ;
        endcase
    end

    // Registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
            r_rf_we    <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_re   <= 1'b0;
            r_rf_wnd   <= '0;
            r_rf_addr  <= '0;
            r_mem_addr <= SPILL_BASE;
        end else begin
            r_busy     <= w_busy_n;
            r_err      <= w_err_n;
            r_rf_we    <= w_rf_we_n;
            r_mem_we   <= w_mem_we_n;
            r_mem_re   <= w_mem_re_n;
            r_rf_wnd   <= w_rf_wnd_n;
            r_rf_addr  <= w_rf_addr_n;
            r_mem_addr <= w_mem_addr_n;
        end
    end

    assign bus.busy      = r_busy;
    assign bus.err       = r_err;
    assign bus.cwp       = r_cwp;
    assign bus.depth     = r_depth;
    assign bus.rf_wnd    = r_rf_wnd;
    assign bus.rf_addr   = r_rf_addr;
    assign bus.rf_we     = r_rf_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_re    = r_mem_re;
    // Data paths are straight wires: RF read is combinational, memory read is already registered
    assign bus.mem_wdata = DW'(bus.rf_rdata);
    assign bus.rf_wdata  = DW'(bus.mem_rdata);
endmodule

// File: tb/tb_rf_window_ctrl.sv
// Directed bench for rf_window_ctrl with an 8-entry RF model and a 256-word memory model.
module tb_rf_window_ctrl;
    logic clk = 1'b0;
    logic rst;

    rf_window_ctrl_if bus ();

    rf_window_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // RF and memory models; bench preloads the RF through pl_*
    logic [15:0] rf_mem [8];
    logic [15:0] dmem   [256];
    logic        pl_en;
    logic [2:0]  pl_idx;
    logic [15:0] pl_val;
    logic [15:0] mem_rdata_q;

    assign bus.rf_rdata  = rf_mem[bus.rf_wnd + 3'(bus.rf_addr)];
    assign bus.mem_rdata = mem_rdata_q;

    always @(posedge clk) begin
        if (bus.rf_we) rf_mem[bus.rf_wnd + 3'(bus.rf_addr)] <= bus.rf_wdata;
        else if (pl_en) rf_mem[pl_idx] <= pl_val;
        if (bus.mem_we) dmem[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_re) mem_rdata_q <= dmem[bus.mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [2:0] idx, input logic [15:0] val);
        pl_en  = 1'b1;
        pl_idx = idx;
        pl_val = val;
        tick();
        pl_en  = 1'b0;
    endtask

    task automatic do_call();
        bus.call = 1'b1;
        tick();
        bus.call = 1'b0;
    endtask

    task automatic do_ret();
        bus.ret = 1'b1;
        tick();
        bus.ret = 1'b0;
    endtask

    logic [2:0] exp_cwp;
    int         n_wait;

    initial begin
        rst = 1'b1; bus.call = 1'b0; bus.ret = 1'b0;
        pl_en = 1'b0; pl_idx = '0; pl_val = '0;
        tick(); tick();
        rst = 1'b0;
        check("rst_cwp",   32'(bus.cwp), 0);
        check("rst_depth", 32'(bus.depth), 0);
        check("rst_busy",  32'(bus.busy), 0);
        check("rst_err",   32'(bus.err), 0);
        check("rst_maddr", 32'(bus.mem_addr), 32'h80);
        check("rst_mwe",   32'(bus.mem_we), 0);

        preload(3'd0, 16'hAAAA);
        preload(3'd1, 16'h5555);

        // Two calls fit in free windows
        do_call();
        check("c1_cwp",  32'(bus.cwp), 2);
        check("c1_dep",  32'(bus.depth), 1);
        check("c1_busy", 32'(bus.busy), 0);
        check("c1_mwe",  32'(bus.mem_we), 0);
        do_call();
        check("c2_cwp",  32'(bus.cwp), 4);
        check("c2_dep",  32'(bus.depth), 2);
        check("c2_busy", 32'(bus.busy), 0);

        // Third call spills window 0
        do_call();
        check("sp0_busy",  32'(bus.busy), 1);
        check("sp0_mwe",   32'(bus.mem_we), 1);
        check("sp0_maddr", 32'(bus.mem_addr), 32'h80);
        check("sp0_wnd",   32'(bus.rf_wnd), 0);
        check("sp0_wdata", 32'(bus.mem_wdata), 32'hAAAA);
        bus.ret = 1'b1;
        tick();
        check("sp1_maddr", 32'(bus.mem_addr), 32'h81);
        check("sp1_raddr", 32'(bus.rf_addr), 1);
        check("sp1_wdata", 32'(bus.mem_wdata), 32'h5555);
        bus.ret = 1'b0;
        tick();
        check("spd_busy", 32'(bus.busy), 0);
        check("spd_mwe",  32'(bus.mem_we), 0);
        check("spd_cwp",  32'(bus.cwp), 6);
        check("spd_dep",  32'(bus.depth), 3);
        check("spd_m80",  32'(dmem[8'h80]), 32'hAAAA);
        check("spd_m81",  32'(dmem[8'h81]), 32'h5555);
        check("spd_maddr", 32'(bus.mem_addr), 32'h82);

        preload(3'd0, 16'h0000);
        preload(3'd1, 16'h0000);

        // Returns: two resident, third fills
        do_ret();
        check("r1_cwp", 32'(bus.cwp), 4);
        check("r1_dep", 32'(bus.depth), 2);
        do_ret();
        check("r2_cwp",  32'(bus.cwp), 2);
        check("r2_dep",  32'(bus.depth), 1);
        check("r2_busy", 32'(bus.busy), 0);
        do_ret();
        check("f0_busy",  32'(bus.busy), 1);
        check("f0_mre",   32'(bus.mem_re), 1);
        check("f0_maddr", 32'(bus.mem_addr), 32'h80);
        check("f0_rfwe",  32'(bus.rf_we), 0);
        tick();
        check("f1_rfwe",  32'(bus.rf_we), 1);
        check("f1_wnd",   32'(bus.rf_wnd), 0);
        check("f1_raddr", 32'(bus.rf_addr), 0);
        check("f1_wdata", 32'(bus.rf_wdata), 32'hAAAA);
        check("f1_mre",   32'(bus.mem_re), 0);
        tick();
        check("f2_mre",   32'(bus.mem_re), 1);
        check("f2_maddr", 32'(bus.mem_addr), 32'h81);
        tick();
        check("f3_rfwe",  32'(bus.rf_we), 1);
        check("f3_raddr", 32'(bus.rf_addr), 1);
        check("f3_wdata", 32'(bus.rf_wdata), 32'h5555);
        tick();
        check("fd_busy", 32'(bus.busy), 0);
        check("fd_rfwe", 32'(bus.rf_we), 0);
        check("fd_cwp",  32'(bus.cwp), 0);
        check("fd_dep",  32'(bus.depth), 0);
        check("fd_rf0",  32'(rf_mem[0]), 32'hAAAA);
        check("fd_rf1",  32'(rf_mem[1]), 32'h5555);

        // Refused requests
        do_ret();
        check("rz_err",  32'(bus.err), 1);
        check("rz_cwp",  32'(bus.cwp), 0);
        check("rz_busy", 32'(bus.busy), 0);
        tick();
        check("rz_err_clr", 32'(bus.err), 0);
        bus.call = 1'b1; bus.ret = 1'b1;
        tick();
        bus.call = 1'b0; bus.ret = 1'b0;
        check("cr_err", 32'(bus.err), 1);
        check("cr_cwp", 32'(bus.cwp), 0);
        check("cr_dep", 32'(bus.depth), 0);

        // Reset in the middle of a spill
        do_call(); do_call(); do_call();
        tick();
        check("ms_busy",  32'(bus.busy), 1);
        check("ms_maddr", 32'(bus.mem_addr), 32'h81);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("ms_cwp",  32'(bus.cwp), 0);
        check("ms_dep",  32'(bus.depth), 0);
        check("ms_busy_clr", 32'(bus.busy), 0);
        check("ms_mwe",  32'(bus.mem_we), 0);

        // Maximum depth with CWP wrap
        exp_cwp = 3'd0;
        for (int k = 0; k < 64; k++) begin
            do_call();
            n_wait = 0;
            while (bus.busy && n_wait < 8) begin
                tick();
                n_wait++;
            end
            if (bus.busy) check("busy_bound", 32'(bus.busy), 0);
            exp_cwp = exp_cwp + 3'd2;
            check("deep_cwp", 32'(bus.cwp), 32'(exp_cwp));
        end
        check("deep_dep",   32'(bus.depth), 64);
        check("deep_maddr", 32'(bus.mem_addr), 32'hFC);
        do_call();
        check("ovf_err",  32'(bus.err), 1);
        check("ovf_busy", 32'(bus.busy), 0);
        check("ovf_mwe",  32'(bus.mem_we), 0);
        check("ovf_dep",  32'(bus.depth), 64);
        check("ovf_cwp",  32'(bus.cwp), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/rf_window_ctrl.md
Name: rf_window_ctrl

Overview:
- Window-pointer controller for the 8x16 windowed register file (RF).
- Owns the current window pointer (CWP) that drives the RF window input, and services call/return requests from the control unit.
- When the RF runs out of free windows, it sequences register spill to data memory (on call) and fill from data memory (on return), and stalls the core while it does so.

Parameters:
- DW, 16, data width of RF and memory words.
- NREG, 8, physical RF entries (power of 2).
- WND_STEP, 2, CWP increment per call; windows are 4 regs and overlap by 4-WND_STEP.
- MEM_AW, 8, data memory address width.
- SPILL_BASE, 8'h80, first memory word of the spill area.
- MAX_DEPTH, 64, maximum call depth.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- call  in  1  call request, sampled only when busy=0.
- ret  in  1  return request, sampled only when busy=0.
- busy  out  1  registered; high during spill/fill; core must stall.
- err  out  1  one-cycle pulse on a refused request.
- cwp  out  3  current window pointer (the core's window select).
- depth  out  7  current call depth.
- rf_wnd  out  3  window input to RF; equals cwp when IDLE.
- rf_addr  out  2  RF register index used during spill/fill.
- rf_we  out  1  RF write strobe (fill only).
- rf_wdata  out  DW  RF write data, equal to registered mem_rdata.
- rf_rdata  in  DW  RF read port 1 output (combinational).
- mem_addr  out  MEM_AW  data memory address.
- mem_we  out  1  memory write strobe (spill).
- mem_re  out  1  memory read strobe (fill); data returns the next cycle.
- mem_wdata  out  DW  equal to rf_rdata.
- mem_rdata  in  DW  memory read data.

Behaviour:
- Internal state:
  - res: resident windows, range 1..NWIN-1, where NWIN = NREG/WND_STEP = 4.
  - sp: spill pointer in words.
  - i: transfer index.
- Reset (sync, takes priority in any state, aborts any spill/fill):
  - state=IDLE, cwp=0, res=1, depth=0, sp=0.
  - busy=0, err=0, rf_we=0, mem_we=0, mem_re=0, rf_addr=0, mem_addr=SPILL_BASE.
- States: IDLE, SPILL, FILL_RD, FILL_WR. All pointer arithmetic on cwp/rf_wnd is modulo NREG.
- IDLE, call=1 and ret=1 together: err pulse; no other change.
- IDLE, call=1:
  - If depth==MAX_DEPTH: err pulse; no change.
  - Else if res<NWIN-1: cwp+=WND_STEP, res+=1, depth+=1 at that edge; busy stays 0.
  - Else: go to SPILL with i=0, busy=1 from the next cycle.
- SPILL, one cycle per word, i=0..WND_STEP-1:
  - rf_wnd = cwp-(res-1)*WND_STEP (oldest window base), rf_addr=i.
  - mem_addr = SPILL_BASE+sp+i, mem_we=1.
  - On the edge ending i=WND_STEP-1: cwp+=WND_STEP, depth+=1, sp+=WND_STEP, res unchanged; go to IDLE with busy=0.
  - Total busy time: WND_STEP cycles.
- IDLE, ret=1:
  - If depth==0: err pulse; no change.
  - Else if res>1: cwp-=WND_STEP, res-=1, depth-=1 in a single cycle.
  - Else (res==1): sp-=WND_STEP, then go to FILL_RD with i=0.
- FILL_RD: mem_addr=SPILL_BASE+sp+i, mem_re=1; go to FILL_WR.
- FILL_WR:
  - rf_wnd=cwp-WND_STEP, rf_addr=i, rf_we=1, rf_wdata=mem_rdata.
  - If i<WND_STEP-1: i+=1 and return to FILL_RD.
  - Else: cwp-=WND_STEP, depth-=1, res stays 1; go to IDLE.
  - Total busy time: 2*WND_STEP cycles.
- Strobes are low in every state where they are not listed.
- call/ret asserted while busy=1 are ignored (not queued).
- Wrap-around: cwp 6+2 -> 0 and 0-2 -> 6.

Test Plan:
- Reset mid-spill (rst during SPILL i=1) -> next cycle: cwp=0, depth=0, busy=0, mem_we=0.
- From reset, two calls -> cwp 2 then 4, res=3, depth=2, busy never high, no memory strobes.
- Third call (regs phys0=16'hAAAA, phys1=16'h5555) -> busy for 2 cycles; mem writes (0x80, AAAA) then (0x81, 5555); then cwp=6, depth=3, sp=2.
- Three rets from the previous state -> cwp 4 and 2 single-cycle (res to 1); third ret: busy 4 cycles; mem reads at 0x80 and 0x81; RF writes rf_wnd=0, addr 0/1 with AAAA/5555; then cwp=0, depth=0.
- ret at depth 0 -> err one cycle, cwp unchanged; call and ret together -> err, no change.
- Drive 64 calls -> depth=64, cwp wraps correctly throughout, sp=124; 65th call -> err, no memory write.
